// File: rtl/apb_fabric_pkg.sv
// Shared definitions for the fabric-side APB3 controller: bus widths,
// controller state encoding and the default peripheral slot map.
package apb_fabric_pkg;

    // Data and address widths of the MSS fabric master port
    localparam int APB_DW = 32;
    localparam int MSS_AW = 20;

    // Default slot assignment of the turret peripherals
    localparam int SLOT_SERVO   = 0;
    localparam int SLOT_TRIGGER = 1;
    localparam int SLOT_SENSOR  = 2;
    localparam int SLOT_SPARE   = 3;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ABORT  = 2'd2,
        ST_DECERR = 2'd3
    } fab_state_t;

endpackage

// File: rtl/apb_err_status.sv
// Error bookkeeping for the fabric APB controller: sticky timeout and
// decode flags, a saturating error counter and capture of the address of
// the most recent error-terminated transfer. A clear pulse that coincides
// with a new error leaves exactly that error recorded.
module apb_err_status
    import apb_fabric_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              err_clr,
    input  logic              to_event,
    input  logic              dec_event,
    input  logic              err_event,
    input  logic [MSS_AW-1:0] event_addr,
    output logic              to_flag,
    output logic              dec_flag,
    output logic [CW-1:0]     err_cnt,
    output logic [MSS_AW-1:0] err_addr
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic              to_flag_reg;
    logic              dec_flag_reg;
    logic [CW-1:0]     err_cnt_reg;
    logic [MSS_AW-1:0] err_addr_reg;

    // Sticky flags and saturating counter; clear is applied before the new event
    always_ff @(posedge clk) begin
        if (srst) begin
            to_flag_reg  <= 1'b0;
            dec_flag_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else if (err_clr) begin
            to_flag_reg  <= to_event;
            dec_flag_reg <= dec_event;
            err_cnt_reg  <= err_event ? CW'(1) : '0;
        end else begin
            if (to_event) begin
                to_flag_reg <= 1'b1;
            end
            if (dec_event) begin
                dec_flag_reg <= 1'b1;
            end
            if (err_event && (err_cnt_reg != CNT_MAX)) begin
                err_cnt_reg <= err_cnt_reg + CW'(1);
            end
        end
    end

    // Address of the latest error survives a clear so firmware can still read it
    always_ff @(posedge clk) begin
        if (srst) begin
            err_addr_reg <= '0;
        end else if (err_event) begin
            err_addr_reg <= event_addr;
        end
    end

    assign to_flag  = to_flag_reg;
    assign dec_flag = dec_flag_reg;
    assign err_cnt  = err_cnt_reg;
    assign err_addr = err_addr_reg;

endmodule

// File: rtl/apb_fabric_ctrl.sv
// Fabric-side APB3 controller. Decodes the MSS master address into slave
// slots, re-times each transfer with a proper slave setup phase, muxes the
// selected slave's response back to the master and aborts transfers whose
// slave never answers so the processor cannot be stalled indefinitely.
module apb_fabric_ctrl
    import apb_fabric_pkg::*;
#(
    parameter int NSLV      = 4,
    parameter int SLOT_LSB  = 8,
    parameter int SLOT_BITS = 4,
    parameter int TIMEOUT   = 255,
    parameter int CW        = 16
) (
    input  logic                   FAB_CLK,
    input  logic                   FAB_RST,
    input  logic                   MSSPSEL,
    input  logic                   MSSPENABLE,
    input  logic                   MSSPWRITE,
    input  logic [MSS_AW-1:0]      MSSPADDR,
    input  logic [APB_DW-1:0]      MSSPWDATA,
    output logic [APB_DW-1:0]      MSSPRDATA,
    output logic                   MSSPREADY,
    output logic                   MSSPSLVERR,
    output logic [NSLV-1:0]        S_PSEL,
    output logic                   S_PENABLE,
    output logic                   S_PWRITE,
    output logic [SLOT_LSB-1:0]    S_PADDR,
    output logic [APB_DW-1:0]      S_PWDATA,
    input  logic [NSLV*APB_DW-1:0] S_PRDATA,
    input  logic [NSLV-1:0]        S_PREADY,
    input  logic [NSLV-1:0]        S_PSLVERR,
    input  logic                   ERR_CLR,
    output logic                   TO_FLAG,
    output logic                   DEC_FLAG,
    output logic [CW-1:0]          ERR_CNT,
    output logic [MSS_AW-1:0]      ERR_ADDR
);

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    fab_state_t            state_reg;
    logic [NSLV-1:0]       psel_reg;
    logic                  penable_reg;
    logic                  write_reg;
    logic [MSS_AW-1:0]     addr_reg;
    logic [CW-1:0]         wait_cnt_reg;

    logic [SLOT_BITS-1:0]  slot_field;
    logic [NSLV-1:0]       slot_onehot;
    logic [CW-1:0]         cnt_inc;
    logic                  sel_ready;
    logic                  sel_err;
    logic [APB_DW-1:0]     sel_rdata;
    logic [NSLV-1:0][APB_DW-1:0] rdata_masked;
    logic                  xfer_done;
    logic                  abort_event;
    logic                  dec_event;
    logic                  slv_event;

    assign slot_field = MSSPADDR[SLOT_LSB +: SLOT_BITS];
    assign cnt_inc    = wait_cnt_reg + CW'(1);

    // One-hot slot decode; an all-zero result means the slot is unmapped.
    // Read data of every slave is masked by its select so the mux is a plain OR.
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_slot
        assign slot_onehot[gi]  = (slot_field == SLOT_BITS'(gi));
        assign rdata_masked[gi] = S_PRDATA[gi*APB_DW +: APB_DW] & {APB_DW{psel_reg[gi]}};
    end

    // OR-combine the masked read words of all slots
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdata = sel_rdata | rdata_masked[i];
        end
    end

    assign sel_ready = |(S_PREADY  & psel_reg);
    assign sel_err   = |(S_PSLVERR & psel_reg);

    // A slave completion only counts while the master still owns the bus
    assign xfer_done = (state_reg == ST_ACCESS) && penable_reg && MSSPSEL && sel_ready;

    // Transfer sequencing: setup capture, slave setup/enable phases, timeout abort
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RST) begin
            state_reg    <= ST_IDLE;
            psel_reg     <= '0;
            penable_reg  <= 1'b0;
            write_reg    <= 1'b0;
            addr_reg     <= '0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (MSSPSEL && !MSSPENABLE) begin
                        addr_reg     <= MSSPADDR;
                        write_reg    <= MSSPWRITE;
                        wait_cnt_reg <= '0;
                        if (|slot_onehot) begin
                            state_reg <= ST_ACCESS;
                            psel_reg  <= slot_onehot;
                        end else begin
                            state_reg <= ST_DECERR;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!MSSPSEL || xfer_done) begin
                        // Completion or master walked away: release the slave
                        state_reg   <= ST_IDLE;
                        psel_reg    <= '0;
                        penable_reg <= 1'b0;
                    end else if (!penable_reg) begin
                        // First ACCESS cycle is the slave's setup phase
                        penable_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= cnt_inc;
                        if (cnt_inc == TIMEOUT_C) begin
                            state_reg   <= ST_ABORT;
                            psel_reg    <= '0;
                            penable_reg <= 1'b0;
                        end
                    end
                end
                ST_ABORT: begin
                    state_reg <= ST_IDLE;
                end
                ST_DECERR: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Master-side response: slave completion passes through, abort/decode errors are synthesized
    always_comb begin
        MSSPREADY  = 1'b0;
        MSSPSLVERR = 1'b0;
        MSSPRDATA  = '0;
        case (state_reg)
            ST_ACCESS: begin
                if (xfer_done) begin
                    MSSPREADY  = 1'b1;
                    MSSPSLVERR = sel_err;
                    if (!write_reg) begin
                        MSSPRDATA = sel_rdata;
                    end
                end
            end
            ST_ABORT, ST_DECERR: begin
                MSSPREADY  = 1'b1;
                MSSPSLVERR = 1'b1;
            end
            default: begin
                MSSPREADY = 1'b0;
            end
        endcase
    end

    assign S_PSEL    = psel_reg;
    assign S_PENABLE = penable_reg;
    assign S_PWRITE  = MSSPWRITE;
    assign S_PADDR   = MSSPADDR[SLOT_LSB-1:0];
    assign S_PWDATA  = MSSPWDATA;

    assign abort_event = (state_reg == ST_ABORT);
    assign dec_event   = (state_reg == ST_DECERR);
    assign slv_event   = xfer_done && sel_err;

    apb_err_status #(
        .CW (CW)
    ) u_err_status (
        .clk        (FAB_CLK),
        .srst       (FAB_RST),
        .err_clr    (ERR_CLR),
        .to_event   (abort_event),
        .dec_event  (dec_event),
        .err_event  (abort_event | dec_event | slv_event),
        .event_addr (addr_reg),
        .to_flag    (TO_FLAG),
        .dec_flag   (DEC_FLAG),
        .err_cnt    (ERR_CNT),
        .err_addr   (ERR_ADDR)
    );

endmodule

// File: tb/tb_apb_fabric_ctrl.sv
// Self-checking bench for apb_fabric_ctrl: directed scenarios followed by
// randomized transfers, all checked against a transfer-level model of the
// expected master response, latency and error bookkeeping.
module tb_apb_fabric_ctrl;

    localparam int NSLV      = 4;
    localparam int SLOT_LSB  = 8;
    localparam int SLOT_BITS = 4;
    localparam int TIMEOUT   = 255;
    localparam int CW        = 16;
    localparam int LIMIT     = TIMEOUT + 20;

    logic                 FAB_CLK = 1'b0;
    logic                 FAB_RST;
    logic                 MSSPSEL, MSSPENABLE, MSSPWRITE;
    logic [19:0]          MSSPADDR;
    logic [31:0]          MSSPWDATA, MSSPRDATA;
    logic                 MSSPREADY, MSSPSLVERR;
    logic [NSLV-1:0]      S_PSEL;
    logic                 S_PENABLE, S_PWRITE;
    logic [SLOT_LSB-1:0]  S_PADDR;
    logic [31:0]          S_PWDATA;
    logic [NSLV*32-1:0]   S_PRDATA;
    logic [NSLV-1:0]      S_PREADY, S_PSLVERR;
    logic                 ERR_CLR;
    logic                 TO_FLAG, DEC_FLAG;
    logic [CW-1:0]        ERR_CNT;
    logic [19:0]          ERR_ADDR;

    apb_fabric_ctrl #(
        .NSLV(NSLV), .SLOT_LSB(SLOT_LSB), .SLOT_BITS(SLOT_BITS),
        .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .FAB_CLK(FAB_CLK), .FAB_RST(FAB_RST),
        .MSSPSEL(MSSPSEL), .MSSPENABLE(MSSPENABLE), .MSSPWRITE(MSSPWRITE),
        .MSSPADDR(MSSPADDR), .MSSPWDATA(MSSPWDATA), .MSSPRDATA(MSSPRDATA),
        .MSSPREADY(MSSPREADY), .MSSPSLVERR(MSSPSLVERR),
        .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE),
        .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
        .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
        .ERR_CLR(ERR_CLR), .TO_FLAG(TO_FLAG), .DEC_FLAG(DEC_FLAG),
        .ERR_CNT(ERR_CNT), .ERR_ADDR(ERR_ADDR)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- slave behaviour ----------------
    int   wait_cfg [NSLV];
    bit   hang_cfg [NSLV];
    bit   err_cfg  [NSLV];
    int   en_cnt   [NSLV];
    logic [31:0] smem [NSLV][256];
    bit   written  [NSLV][256];

    function automatic logic [31:0] base_word(input int slot, input int off);
        return 32'hC0DE_0000 | (slot << 8) | off;
    endfunction

    always_comb begin
        S_PREADY  = '0;
        S_PSLVERR = '0;
        S_PRDATA  = '0;
        for (int i = 0; i < NSLV; i++) begin
            S_PREADY[i]  = S_PSEL[i] && S_PENABLE && !hang_cfg[i] && (en_cnt[i] >= wait_cfg[i]);
            S_PSLVERR[i] = err_cfg[i];
            S_PRDATA[32*i +: 32] = written[i][S_PADDR] ? smem[i][S_PADDR] : base_word(i, int'(S_PADDR));
        end
    end

    always @(posedge FAB_CLK) begin
        for (int i = 0; i < NSLV; i++) begin
            if (!S_PSEL[i]) begin
                en_cnt[i] <= 0;
            end else if (S_PENABLE && !S_PREADY[i]) begin
                en_cnt[i] <= en_cnt[i] + 1;
            end
            if (S_PSEL[i] && S_PENABLE && S_PREADY[i] && S_PWRITE && !err_cfg[i]) begin
                smem[i][S_PADDR]    <= S_PWDATA;
                written[i][S_PADDR] <= 1'b1;
            end
        end
    end

    // Select monitor: only the slot of the current transfer may ever be selected
    logic [NSLV-1:0] allow_mask = '0;
    int mon_bad = 0;
    always @(negedge FAB_CLK) begin
        if ((S_PSEL & ~allow_mask) != '0) mon_bad <= mon_bad + 1;
        if (S_PENABLE && (S_PSEL == '0)) mon_bad <= mon_bad + 1;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_mem [NSLV][256];
    bit          m_to, m_dec;
    int          m_cnt;
    logic [19:0] m_addr;

    task automatic model_reset();
        m_to = 0; m_dec = 0; m_cnt = 0; m_addr = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic check_status(input string tag);
        check({tag, ".to_flag"},  TO_FLAG,  m_to);
        check({tag, ".dec_flag"}, DEC_FLAG, m_dec);
        check({tag, ".err_cnt"},  ERR_CNT,  m_cnt);
        check({tag, ".err_addr"}, ERR_ADDR, m_addr);
    endtask

    // One master transfer; master leaves SEL/ENABLE high afterwards so the
    // next call starts its setup in the cycle right after completion.
    task automatic xfer(input logic [19:0] addr, input logic wr, input logic [31:0] wd, input bit clr);
        int slot, off, exp_lat, cyc;
        bit dec, hang, serr;
        logic [31:0] exp_rd;
        logic [NSLV-1:0] exp_sel;
        slot = int'(addr[11:8]);
        off  = int'(addr[7:0]);
        dec  = (slot >= NSLV);
        hang = 0; serr = 0; exp_lat = 0; exp_sel = '0; exp_rd = '0;
        if (!dec) begin
            hang    = hang_cfg[slot];
            serr    = err_cfg[slot];
            exp_lat = hang ? TIMEOUT + 1 : 1 + wait_cfg[slot];
            exp_sel = NSLV'(1) << slot;
            if (!hang && !wr) exp_rd = exp_mem[slot][off];
        end

        @(negedge FAB_CLK);
        allow_mask = exp_sel;
        MSSPSEL = 1'b1; MSSPENABLE = 1'b0;
        MSSPADDR = addr; MSSPWRITE = wr; MSSPWDATA = wd;
        @(negedge FAB_CLK);
        MSSPENABLE = 1'b1;
        #1;
        cyc = 0;
        while (!MSSPREADY && cyc < LIMIT) begin
            @(negedge FAB_CLK);
            #1;
            cyc++;
        end
        check("ready", MSSPREADY, 1'b1);
        check("latency", cyc, exp_lat);
        check("slverr", MSSPSLVERR, dec || hang || serr);
        check("rdata", MSSPRDATA, exp_rd);
        check("psel_at_ready", S_PSEL, (dec || hang) ? '0 : exp_sel);
        if (!dec && !hang) begin
            check("paddr", S_PADDR, addr[7:0]);
            check("pwrite", S_PWRITE, wr);
            check("pwdata", S_PWDATA, wd);
        end
        if (clr) ERR_CLR = 1'b1;
        @(posedge FAB_CLK);
        #1;
        ERR_CLR = 1'b0;
        check("psel_after", S_PSEL, '0);
        check("penable_after", S_PENABLE, 1'b0);
        check("ready_after", MSSPREADY, 1'b0);

        if (clr) begin m_to = 0; m_dec = 0; m_cnt = 0; end
        if (dec || hang || serr) begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (hang) m_to = 1;
            if (dec)  m_dec = 1;
            m_addr = addr;
        end
        if (wr && !dec && !hang && !serr) exp_mem[slot][off] = wd;
        check_status("status");
        $display("xfer addr=%05h %s wd=%08h rd=%08h slverr=%0d lat=%0d err_cnt=%0d",
                 addr, wr ? "WR" : "RD", wd, MSSPRDATA, MSSPSLVERR, cyc, ERR_CNT);
    endtask

    initial begin
        int slot, off, hi;
        logic [19:0] a;
        FAB_RST = 1'b1;
        MSSPSEL = 0; MSSPENABLE = 0; MSSPWRITE = 0; MSSPADDR = '0; MSSPWDATA = '0; ERR_CLR = 0;
        for (int i = 0; i < NSLV; i++) begin
            wait_cfg[i] = 0; hang_cfg[i] = 0; err_cfg[i] = 0;
            for (int j = 0; j < 256; j++) exp_mem[i][j] = base_word(i, j);
        end
        model_reset();
        repeat (3) @(posedge FAB_CLK);
        #1;
        check("rst.psel", S_PSEL, '0);
        check("rst.penable", S_PENABLE, 1'b0);
        check("rst.ready", MSSPREADY, 1'b0);
        check("rst.slverr", MSSPSLVERR, 1'b0);
        check("rst.rdata", MSSPRDATA, '0);
        check_status("rst");
        @(negedge FAB_CLK);
        FAB_RST = 1'b0;

        // Write with two slave wait states
        wait_cfg[1] = 2;
        xfer(20'h00110, 1'b1, 32'hA5A5_0001, 1'b0);
        // Zero-wait write then read back on slot 2
        wait_cfg[2] = 0;
        xfer(20'h00240, 1'b1, 32'h1234_5678, 1'b0);
        xfer(20'h00240, 1'b0, 32'h0, 1'b0);
        // Unmapped slot
        xfer(20'h00500, 1'b0, 32'h0, 1'b0);
        // Hung slave hits the timeout
        hang_cfg[0] = 1;
        xfer(20'h00004, 1'b0, 32'h0, 1'b0);
        hang_cfg[0] = 0;
        // Slave error on a read
        err_cfg[3] = 1;
        xfer(20'h00308, 1'b0, 32'h0, 1'b0);
        err_cfg[3] = 0;
        // Clear pulse coinciding with an abort
        hang_cfg[0] = 1;
        xfer(20'h0A00C, 1'b0, 32'h0, 1'b1);
        hang_cfg[0] = 0;

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NSLV; i++) begin
                wait_cfg[i] = $urandom_range(0, 3);
                hang_cfg[i] = ($urandom_range(0, 15) == 0);
                err_cfg[i]  = ($urandom_range(0, 4) == 0);
            end
            slot = $urandom_range(0, 6);
            off  = $urandom_range(0, 63) * 4;
            hi   = $urandom_range(0, 255);
            a    = {hi[7:0], slot[3:0], off[7:0]};
            xfer(a, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < NSLV; i++) begin
            hang_cfg[i] = 0; err_cfg[i] = 0; wait_cfg[i] = 1;
        end

        // Standalone clear keeps the captured address
        @(negedge FAB_CLK);
        MSSPSEL = 0; MSSPENABLE = 0;
        ERR_CLR = 1'b1;
        @(negedge FAB_CLK);
        ERR_CLR = 1'b0;
        m_to = 0; m_dec = 0; m_cnt = 0;
        check_status("clr");
        $display("err_clr err_cnt=%0d err_addr=%05h", ERR_CNT, ERR_ADDR);

        // Reset in the middle of a hung access
        hang_cfg[0] = 1;
        allow_mask = 4'b0001;
        MSSPSEL = 1; MSSPENABLE = 0; MSSPADDR = 20'h00020; MSSPWRITE = 0;
        @(negedge FAB_CLK);
        MSSPENABLE = 1;
        repeat (5) @(negedge FAB_CLK);
        check("mid.psel", S_PSEL, 4'b0001);
        FAB_RST = 1'b1;
        @(posedge FAB_CLK);
        #1;
        model_reset();
        check("midrst.psel", S_PSEL, '0);
        check("midrst.penable", S_PENABLE, 1'b0);
        check("midrst.ready", MSSPREADY, 1'b0);
        check("midrst.slverr", MSSPSLVERR, 1'b0);
        check("midrst.rdata", MSSPRDATA, '0);
        check_status("midrst");
        $display("reset mid-access psel=%b err_cnt=%0d", S_PSEL, ERR_CNT);
        @(negedge FAB_CLK);
        FAB_RST = 1'b0; MSSPSEL = 0; MSSPENABLE = 0;
        hang_cfg[0] = 0;

        // Recovery transfer after reset
        xfer(20'h00240, 1'b0, 32'h0, 1'b0);
        @(negedge FAB_CLK);
        MSSPSEL = 0; MSSPENABLE = 0;
        @(negedge FAB_CLK);
        check("select_monitor", mon_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
